spi_flash_responder: RTL
========================

# spi_flash_responder

SPI target that answers flash-style read commands from an external SPI host. It serves bytes out of a word-wide on-chip read port. It plays the flash side of the same serial protocol that `spi_flash` initiates, so the system can act as a boot or data source for another device, or run a loopback self-test against `spi_flash`. All SPI pins are oversampled and synchronized into `clk`. No logic runs on the SPI clock.

## Interface
Parameters:
- `JEDEC_ID`, 24'hEF4016: three bytes returned MSB-first for command 0x9F.
- `MEM_LATENCY`, 4: maximum `clk` cycles from `mem_rstrb` to `mem_rvalid` that the host timing budget allows.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `spi_clk`  in  1  host SCK, mode 0, idle low.
- `spi_cs_n`  in  1  host chip select, active low.
- `spi_mosi`  in  1  host data in.
- `spi_miso`  out  1  data to host.
- `spi_miso_oe`  out  1  high only while this block drives `spi_miso`.
- `mem_rstrb`  out  1  one-cycle word read request.
- `mem_word_addr`  out  22  word address (byte address [23:2]).
- `mem_rdata`  in  32  read data, sampled when `mem_rvalid` is high.
- `mem_rvalid`  in  1  one-cycle response pulse.
- `active`  out  1  synchronized CS asserted (status/LED).

## Operation
- **Synchronization:** SCK, CS_n and MOSI each pass through two flops. SCK rise and fall are then detected from a third flop.
- **SCK edges:** MOSI is sampled on detected rising edges. MISO is updated on detected falling edges.
- **State machine:** IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
  - IDLE → CMD when synchronized CS falls. The bit counter is cleared.
  - CMD: shift 8 bits, MSB first. 0x03 → ADDR. 0x0B → ADDR with the dummy flag set. 0x9F → ID. Any other opcode → IGNORE.
  - ADDR: shift 24 bits, MSB first, into the byte address. On the 24th bit, pulse `mem_rstrb` with addr[23:2]. Then go to DUMMY if the flag is set, else DATA.
  - DUMMY: count 8 rising edges, then go to DATA.
  - DATA: serve bytes from the current word at lane addr[1:0]. Lane 0 is byte [7:0] (little-endian, matching `spi_flash` assembly). Bits go out MSB first. After each 8th bit the byte address increments; lane 3 → 0 advances to the prefetched word.
  - ID: shift out `JEDEC_ID[23:0]`. After 24 bits, output 0xFF.
  - IGNORE: do nothing until CS rises.
- **Prefetch:** when the first bit of lane 3 is driven, pulse `mem_rstrb` for word+1. The response is held in a next-word buffer.
- **Address wrap:** the byte address is 24 bits and wraps from 0xFFFFFF to 0x000000. The word address wraps correspondingly.
- **MISO drive:**
  - `spi_miso_oe` is high only in DATA and ID with CS low.
  - `spi_miso` is high whenever not driving.
  - The first data bit is presented on the falling edge after the last address/dummy bit.
- **CS deassert:** a synchronized CS rise in any state forces IDLE, drops `spi_miso_oe` that cycle, and clears the counters.
  - A read that is outstanding at that point has its later `mem_rvalid` absorbed and discarded.
  - No new `mem_rstrb` is issued until the next transaction.
- **Reset values:** `spi_miso`=1, `spi_miso_oe`=0, `mem_rstrb`=0, `mem_word_addr`=0, `active`=0. State is IDLE and buffers are cleared.

## Timing
- **SCK limits:** high and low phases must each be ≥ `MEM_LATENCY`+4 `clk` cycles (8 by default). CS setup before the first SCK rise must be ≥ 4 cycles.
- **Input-to-action latency:** 3 `clk` cycles from a pin edge to the internal action.
- **First word:** `mem_rstrb` rises 1 cycle after the last address bit is sampled. The word is registered on `mem_rvalid` and must be present before the next SCK fall.
- **Missing data:** if `mem_rvalid` has not arrived by that fall, `spi_miso` outputs 1s for that byte. This is a timing violation and is not recovered.
- **Request discipline:** at most one read outstanding. `mem_rstrb` never repeats while waiting.
- **`active`:** follows synchronized CS_n inverted, with 2-cycle latency.

## Structure
- **Shared package:** opcode constants (`SPI_CMD_READ`=8'h03, `SPI_CMD_FAST_READ`=8'h0B, `SPI_CMD_JEDEC_ID`=8'h9F) and the state encoding. `spi_flash` reuses the opcodes.
- **Sub-module `spi_pin_sync`:** the 2-flop synchronizers plus edge detector for the three SPI inputs. The responder core holds the FSM, shift registers, word buffers and read port.

## Test plan
- **0x03 read:** CS low, send 0x03 then address 0x000001. Memory word 0 = 0x44332211, word 1 = 0x88776655. Read 5 bytes → 0x22, 0x33, 0x44, 0x55, 0x66. Exactly 2 `mem_rstrb` pulses, at word addresses 0 and 1.
- **0x0B read:** send 0x0B, address 0x000004, one dummy byte, read 4 bytes → 0x55, 0x66, 0x77, 0x88. `spi_miso_oe` stays low through the dummy byte.
- **JEDEC ID:** send 0x9F, read 4 bytes → 0xEF, 0x40, 0x16, 0xFF.
- **Unknown opcode:** send 0x05 and clock 16 more bits → `spi_miso_oe` stays 0 and there is no `mem_rstrb`.
- **Wrap-around:** read at address 0xFFFFFE for 4 bytes → second word requested at word address 0. Returned bytes are lanes 2, 3, then lanes 0, 1 of word 0.
- **Abort and reset:** raise CS mid-byte while a read is outstanding, with `mem_rvalid` arriving after CS rises → block is IDLE, `spi_miso_oe`=0, and the next 0x03 transaction returns correct data. Asserting `reset` mid-DATA sets all outputs to their reset values immediately.

Source files
------------

// File: rtl/spi_flash_responder_pkg.sv
// spi_flash_responder_pkg: shared SPI flash opcodes, responder state encoding and byte-lane helper
package spi_flash_responder_pkg;

    localparam logic [7:0] SPI_CMD_READ      = 8'h03;
    localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] SPI_CMD_JEDEC_ID  = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_ID,
        ST_IGNORE
    } state_e;

    // Lane 0 is bits [7:0]: words are assembled little-endian.
    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
        return w[{l, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/spi_flash_responder_pin_sync.sv
// spi_pin_sync: two-flop synchronizers for SCK/CS_n/MOSI plus edge detection from a third flop
// Ports: clk/rst (async, active-high); spi_*_i raw pins; sck_rise_o/sck_fall_o/cs_rise_o/cs_fall_o
// one-cycle edge strobes; cs_n_o/mosi_o synchronized levels.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk_i,
    input  logic spi_cs_n_i,
    input  logic spi_mosi_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_rise_o,
    output logic cs_fall_o,
    output logic cs_n_o,
    output logic mosi_o
);

    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], spi_clk_i};
            cs_q   <= {cs_q[1:0], spi_cs_n_i};
            mosi_q <= {mosi_q[0], spi_mosi_i};
        end
    end

    assign sck_rise_o = sck_q[1] & ~sck_q[2];
    assign sck_fall_o = ~sck_q[1] & sck_q[2];
    assign cs_rise_o  = cs_q[1] & ~cs_q[2];
    assign cs_fall_o  = ~cs_q[1] & cs_q[2];
    assign cs_n_o     = cs_q[1];
    assign mosi_o     = mosi_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI flash target serving 0x03/0x0B reads from a word read port and 0x9F JEDEC ID
// Ports: clk, reset (async, active-high); spi_clk/spi_cs_n/spi_mosi host pins; spi_miso/spi_miso_oe
// target data and drive enable; mem_rstrb/mem_word_addr one-cycle word read request; mem_rdata/mem_rvalid
// read response; active = synchronized chip select asserted.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        mem_rstrb,
    output logic [21:0] mem_word_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        active
);

    logic sck_rise, sck_fall, cs_rise, cs_fall, cs_n_s, mosi_s;

    spi_pin_sync u_sync (
        .clk        (clk),
        .rst        (reset),
        .spi_clk_i  (spi_clk),
        .spi_cs_n_i (spi_cs_n),
        .spi_mosi_i (spi_mosi),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_rise_o  (cs_rise),
        .cs_fall_o  (cs_fall),
        .cs_n_o     (cs_n_s),
        .mosi_o     (mosi_s)
    );

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d, addr_q, addr_d;
    logic [21:0] waddr_q, waddr_d;
    logic [31:0] cur_q, cur_d, nxt_q, nxt_d;
    logic [7:0]  age_q, age_d;
    logic        fast_q, fast_d, miso_q, miso_d, rstrb_q, rstrb_d;
    logic        pend_q, pend_d, pend_cur_q, pend_cur_d, drop_q, drop_d;
    logic        cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
    logic [23:0] sh_in;
    logic [7:0]  cur_byte;

    assign sh_in    = {sh_q[22:0], mosi_s};
    assign cur_byte = lane_byte(cur_q, addr_q[1:0]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        waddr_d    = waddr_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        fast_d     = fast_q;
        miso_d     = miso_q;
        rstrb_d    = 1'b0;
        pend_d     = pend_q;
        pend_cur_d = pend_cur_q;
        drop_d     = drop_q;
        cur_v_d    = cur_v_q;
        nxt_v_d    = nxt_v_q;
        // A response to an aborted transaction is consumed but never stored.
        if (mem_rvalid && pend_q) begin
            pend_d = 1'b0;
            drop_d = 1'b0;
            if (!drop_q && pend_cur_q) begin
                cur_d   = mem_rdata;
                cur_v_d = 1'b1;
            end else if (!drop_q) begin
                nxt_d   = mem_rdata;
                nxt_v_d = 1'b1;
            end
        end
        // An aborted read that is past its latency budget will never answer; stop waiting for it.
        if (pend_q && drop_q && age_q > 8'(MEM_LATENCY)) begin
            pend_d = 1'b0;
            drop_d = 1'b0;
        end
        if (cs_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            fast_d  = 1'b0;
            cur_v_d = 1'b0;
            nxt_v_d = 1'b0;
            drop_d  = pend_d;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
                ST_CMD: if (sck_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = '0;
                        fast_d  = sh_in[7:0] == SPI_CMD_FAST_READ;
                        state_d = (sh_in[7:0] == SPI_CMD_READ || sh_in[7:0] == SPI_CMD_FAST_READ) ? ST_ADDR :
                                  (sh_in[7:0] == SPI_CMD_JEDEC_ID) ? ST_ID : ST_IGNORE;
                    end
                end
                ST_ADDR: if (sck_rise) begin
                    sh_d  = sh_in;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        cnt_d   = '0;
                        addr_d  = sh_in;
                        state_d = fast_q ? ST_DUMMY : ST_DATA;
                        if (!pend_d) begin
                            rstrb_d    = 1'b1;
                            pend_d     = 1'b1;
                            pend_cur_d = 1'b1;
                            waddr_d    = sh_in[23:2];
                        end
                    end
                end
                ST_DUMMY: if (sck_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: if (sck_fall) begin
                    miso_d = cur_v_q ? cur_byte[3'd7 - cnt_q[2:0]] : 1'b1;
                    // Prefetch the following word as soon as the last lane of this one starts.
                    if (cnt_q == 5'd0 && addr_q[1:0] == 2'd3 && !pend_d) begin
                        rstrb_d    = 1'b1;
                        pend_d     = 1'b1;
                        pend_cur_d = 1'b0;
                        waddr_d    = addr_q[23:2] + 22'd1;
                    end
                end else if (sck_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d  = '0;
                        addr_d = addr_q + 24'd1;
                        if (addr_q[1:0] == 2'd3) begin
                            cur_d   = nxt_q;
                            cur_v_d = nxt_v_q;
                            nxt_v_d = 1'b0;
                        end
                    end
                end
                ST_ID: if (sck_fall) begin
                    miso_d = (cnt_q < 5'd24) ? JEDEC_ID[5'd23 - cnt_q] : 1'b1;
                end else if (sck_rise && cnt_q < 5'd24) begin
                    cnt_d = cnt_q + 5'd1;
                end
                default: ;
            endcase
        end
        age_d = rstrb_d ? 8'd0 : (age_q == 8'hFF) ? age_q : age_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            waddr_q    <= '0;
            cur_q      <= '0;
            nxt_q      <= '0;
            age_q      <= '0;
            fast_q     <= 1'b0;
            miso_q     <= 1'b1;
            rstrb_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_cur_q <= 1'b0;
            drop_q     <= 1'b0;
            cur_v_q    <= 1'b0;
            nxt_v_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            waddr_q    <= waddr_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            age_q      <= age_d;
            fast_q     <= fast_d;
            miso_q     <= miso_d;
            rstrb_q    <= rstrb_d;
            pend_q     <= pend_d;
            pend_cur_q <= pend_cur_d;
            drop_q     <= drop_d;
            cur_v_q    <= cur_v_d;
            nxt_v_q    <= nxt_v_d;
        end
    end

    // Enable uses the synchronized CS level so it drops in the same cycle the CS rise is seen.
    assign spi_miso_oe   = (state_q == ST_DATA || state_q == ST_ID) && !cs_n_s;
    assign spi_miso      = spi_miso_oe ? miso_q : 1'b1;
    assign mem_rstrb     = rstrb_q;
    assign mem_word_addr = waddr_q;
    assign active        = ~cs_n_s;

endmodule
